// File: rtl/vga_bus_pkg.sv
// vga_bus_pkg: register offsets, CTRL/STATUS bit indices and FSM encoding for vga_bus_ctrl
package vga_bus_pkg;
  localparam logic [2:0] OFF_X        = 3'd0;
  localparam logic [2:0] OFF_Y        = 3'd1;
  localparam logic [2:0] OFF_PIXEL    = 3'd2;
  localparam logic [2:0] OFF_CTRL     = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_COL_LO   = 3'd5;
  localparam logic [2:0] OFF_COL_HI   = 3'd6;
  localparam logic [2:0] OFF_FILL_VAL = 3'd7;
  localparam int CTRL_AUTO_INC   = 0;
  localparam int CTRL_FILL_START = 1;
  localparam int CTRL_FILL_ABORT = 2;
  localparam int STAT_BUSY       = 0;
  localparam int STAT_DONE       = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_PIX_WR, ST_FILL, ST_FILL_END} state_e;
endpackage

// File: rtl/vga_xy_stepper.sv
// vga_xy_stepper: next raster position; X wraps at X_MAX-1 carrying into Y, Y wraps at Y_MAX-1
// Ports: x_i/y_i current position, x_o/y_o next position (combinational)
module vga_xy_stepper #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 7,
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120
) (
  input  logic [X_WIDTH-1:0] x_i,
  input  logic [Y_WIDTH-1:0] y_i,
  output logic [X_WIDTH-1:0] x_o,
  output logic [Y_WIDTH-1:0] y_o
);
  logic x_end, y_end;
  assign x_end = x_i == X_WIDTH'(X_MAX - 1);
  assign y_end = y_i == Y_WIDTH'(Y_MAX - 1);
  assign x_o   = x_end ? '0 : x_i + 1'b1;
  assign y_o   = x_end ? (y_end ? '0 : y_i + 1'b1) : y_i;
endmodule

// File: rtl/vga_bus_ctrl.sv
// vga_bus_ctrl: bus-mapped frame-buffer port A controller with auto-increment, readback and fill engine
// Ports: CLK/RESET (sync, active-high); BUS_DATA/BUS_ADDR/BUS_WE processor bus, BUS_DATA driven
//        only the cycle after an in-range read; FB_* frame buffer port A; CONFIG_COLOURS {COL_HI,COL_LO};
//        BUSY fill active; DONE_IRQ one-cycle fill-complete pulse
module vga_bus_ctrl
  import vga_bus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'hB0,
  parameter int         X_WIDTH     = 8,
  parameter int         Y_WIDTH     = 7,
  parameter int         X_MAX       = 160,
  parameter int         Y_MAX       = 120,
  parameter int         PIXEL_WIDTH = 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  inout  wire  [7:0]                 BUS_DATA,
  input  logic [7:0]                 BUS_ADDR,
  input  logic                       BUS_WE,
  output logic [X_WIDTH+Y_WIDTH-1:0] FB_ADDR,
  output logic [PIXEL_WIDTH-1:0]     FB_DATA_OUT,
  output logic                       FB_WE,
  input  logic [PIXEL_WIDTH-1:0]     FB_DATA_IN,
  output logic [15:0]                CONFIG_COLOURS,
  output logic                       BUSY,
  output logic                       DONE_IRQ
);
  if (PIXEL_WIDTH < 1 || PIXEL_WIDTH > 8 || X_WIDTH > 8 || Y_WIDTH > 8 ||
      X_MAX > 2**X_WIDTH || Y_MAX > 2**Y_WIDTH || int'(BASE_ADDR) + 7 > 255) begin : g_param_check
    $error("vga_bus_ctrl: unsupported parameter combination");
  end
  state_e                 state_q;
  logic [X_WIDTH-1:0]     x_q, fx_q, step_x, fstep_x;
  logic [Y_WIDTH-1:0]     y_q, fy_q, step_y, fstep_y;
  logic [15:0]            col_q;
  logic [7:0]             fill_val_q, rd_data_d, rd_data_q, status, off, wr_hit;
  logic [PIXEL_WIDTH-1:0] fb_dout_q;
  logic                   auto_inc_q, done_q, irq_q, rd_en_q, fb_we_q, busy_q;
  logic                   sel, rd_status, pix_wr, fill_go, abort, fill_last, done_set;
  // Offset relative to the base; anything that lands beyond 7 is outside our window.
  assign off       = BUS_ADDR - BASE_ADDR;
  assign sel       = off < 8'd8;
  assign wr_hit    = (sel && BUS_WE) ? 8'd1 << off[2:0] : 8'd0;
  assign rd_status = sel && !BUS_WE && off[2:0] == OFF_STATUS;
  assign pix_wr    = wr_hit[OFF_PIXEL] && !busy_q;
  assign fill_go   = wr_hit[OFF_CTRL] && BUS_DATA[CTRL_FILL_START] && !busy_q;
  assign abort     = wr_hit[OFF_CTRL] && BUS_DATA[CTRL_FILL_ABORT] && busy_q;
  assign fill_last = busy_q && fx_q == X_WIDTH'(X_MAX - 1) && fy_q == Y_WIDTH'(Y_MAX - 1);
  assign done_set  = abort || fill_last;
  vga_xy_stepper #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_reg_step (
    .x_i(x_q), .y_i(y_q), .x_o(step_x), .y_o(step_y)
  );
  vga_xy_stepper #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_fill_step (
    .x_i(fx_q), .y_i(fy_q), .x_o(fstep_x), .y_o(fstep_y)
  );
  // A STATUS read coinciding with completion reports DONE and keeps it set.
  always_comb begin
    status = '0;
    status[STAT_BUSY] = busy_q;
    status[STAT_DONE] = done_q || done_set;
    rd_data_d = off[2:0] == OFF_X      ? 8'(x_q) :
                off[2:0] == OFF_Y      ? 8'(y_q) :
                off[2:0] == OFF_PIXEL  ? 8'(FB_DATA_IN) :
                off[2:0] == OFF_CTRL   ? {7'd0, auto_inc_q} :
                off[2:0] == OFF_STATUS ? status :
                off[2:0] == OFF_COL_LO ? col_q[7:0] :
                off[2:0] == OFF_COL_HI ? col_q[15:8] : fill_val_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      fx_q       <= '0;
      fy_q       <= '0;
      col_q      <= '0;
      fill_val_q <= '0;
      auto_inc_q <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_data_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_dout_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      rd_en_q   <= sel && !BUS_WE;
      rd_data_q <= rd_data_d;
      done_q    <= done_set || (done_q && !rd_status);
      irq_q     <= done_set;
      if (wr_hit[OFF_CTRL]) auto_inc_q <= BUS_DATA[CTRL_AUTO_INC];
      if (wr_hit[OFF_COL_LO]) col_q[7:0] <= BUS_DATA;
      if (wr_hit[OFF_COL_HI]) col_q[15:8] <= BUS_DATA;
      if (wr_hit[OFF_FILL_VAL] && !busy_q) fill_val_q <= BUS_DATA;
      if (state_q == ST_PIX_WR && auto_inc_q) begin
        x_q <= step_x;
        y_q <= step_y;
      end else begin
        if (wr_hit[OFF_X] && !busy_q) x_q <= BUS_DATA[X_WIDTH-1:0];
        if (wr_hit[OFF_Y] && !busy_q) y_q <= BUS_DATA[Y_WIDTH-1:0];
      end
      if (busy_q) begin
        fx_q <= fstep_x;
        fy_q <= fstep_y;
        if (done_set) begin
          state_q <= ST_FILL_END;
          fb_we_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      end else if (pix_wr) begin
        state_q   <= ST_PIX_WR;
        fb_we_q   <= 1'b1;
        fb_dout_q <= BUS_DATA[PIXEL_WIDTH-1:0];
      end else if (fill_go) begin
        state_q   <= ST_FILL;
        fb_we_q   <= 1'b1;
        busy_q    <= 1'b1;
        fx_q      <= '0;
        fy_q      <= '0;
        fb_dout_q <= fill_val_q[PIXEL_WIDTH-1:0];
      end else begin
        state_q <= ST_IDLE;
        fb_we_q <= 1'b0;
      end
    end
  end
  assign BUS_DATA       = rd_en_q ? rd_data_q : 8'bz;
  assign FB_ADDR        = busy_q ? {fy_q, fx_q} : {y_q, x_q};
  assign FB_DATA_OUT    = fb_dout_q;
  assign FB_WE          = fb_we_q;
  assign CONFIG_COLOURS = col_q;
  assign BUSY           = busy_q;
  assign DONE_IRQ       = irq_q;
endmodule

// File: tb/tb_vga_bus_ctrl.sv
// tb_vga_bus_ctrl: scoreboard bench for vga_bus_ctrl with a behavioural frame buffer on port A
module tb_vga_bus_ctrl;
  localparam logic [7:0] BASE = 8'hB0;
  logic        clk = 1'b0, rst = 1'b1, bus_we = 1'b0, bus_oe = 1'b0;
  logic [7:0]  bus_addr = 8'h00, bus_drv = 8'h00, d1, d2;
  wire  [7:0]  bus_data;
  logic [14:0] fb_addr;
  logic [0:0]  fb_dout, fb_din;
  logic        fb_we, busy, irq;
  logic [15:0] colours;
  logic [0:0]  mem [0:32767];
  logic [15:0] exp_q [$];
  int          n_checks = 0, n_fail = 0, we_cnt = 0;
  assign bus_data = bus_oe ? bus_drv : 8'bz;
  pullup (bus_data);
  always #5 clk = ~clk;
  vga_bus_ctrl dut (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .FB_ADDR(fb_addr), .FB_DATA_OUT(fb_dout), .FB_WE(fb_we), .FB_DATA_IN(fb_din),
    .CONFIG_COLOURS(colours), .BUSY(busy), .DONE_IRQ(irq)
  );
  initial for (int i = 0; i < 32768; i++) mem[i] = 1'b0;
  always @(posedge clk) begin
    if (fb_we) mem[fb_addr] <= fb_dout;
    fb_din <= mem[fb_addr];
  end
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      logic [15:0] e;
      we_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fb_write_unexpected: got addr=%h data=%h, expected no write", fb_addr, fb_dout);
      end else begin
        e = exp_q.pop_front();
        if ({fb_addr, fb_dout} !== e) begin
          n_fail++;
          $display("FAIL fb_write: got addr=%h data=%h, expected addr=%h data=%h", fb_addr, fb_dout, e[15:1], e[0]);
        end
      end
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    step();
    bus_addr = a; bus_drv = d; bus_oe = 1'b1; bus_we = 1'b1;
    step();
    bus_addr = 8'h00; bus_oe = 1'b0; bus_we = 1'b0;
  endtask
  task automatic bus_read(input logic [7:0] a, output logic [7:0] r1, output logic [7:0] r2);
    step();
    bus_addr = a; bus_we = 1'b0; bus_oe = 1'b0;
    step();
    bus_addr = 8'h00;
    @(negedge clk);
    r1 = bus_data;
    step();
    @(negedge clk);
    r2 = bus_data;
  endtask
  task automatic test_reset();
    step(); step(); step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_fb_we: got %b, expected 0", fb_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b, expected 0", irq); end
    n_checks++; if (colours !== 16'h0000) begin n_fail++; $display("FAIL reset_colours: got %h, expected 0000", colours); end
    n_checks++; if (bus_data !== 8'hFF) begin n_fail++; $display("FAIL reset_bus_released: got %h, expected ff (pulled up)", bus_data); end
    bus_read(BASE + 8'd0, d1, d2);
    n_checks++; if (d1 !== 8'h00) begin n_fail++; $display("FAIL reset_x: got %h, expected 00", d1); end
    bus_read(BASE + 8'd4, d1, d2);
    n_checks++; if (d1 !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h, expected 00", d1); end
  endtask
  task automatic test_pixel_write();
    bus_write(BASE + 8'd0, 8'd5);
    bus_write(BASE + 8'd1, 8'd3);
    exp_q.push_back({7'd3, 8'd5, 1'b1});
    bus_write(BASE + 8'd2, 8'h01);
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b1) begin n_fail++; $display("FAIL pixel_fb_we: got %b, expected 1", fb_we); end
    bus_write(BASE + 8'd0, 8'd6);
    exp_q.push_back({7'd3, 8'd6, 1'b0});
    bus_write(BASE + 8'd2, 8'hFE);
    bus_read(BASE + 8'd0, d1, d2);
    n_checks++; if (d1 !== 8'd6) begin n_fail++; $display("FAIL pixel_x_unchanged: got %h, expected 06", d1); end
    bus_write(BASE + 8'd0, 8'd5);
    bus_read(BASE + 8'd2, d1, d2);
    n_checks++; if (d1 !== 8'h01) begin n_fail++; $display("FAIL pixel_readback: got %h, expected 01", d1); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pixel_pending: got %0d, expected 0", exp_q.size()); end
  endtask
  task automatic test_auto_inc();
    bus_write(BASE + 8'd3, 8'h01);
    bus_read(BASE + 8'd3, d1, d2);
    n_checks++; if (d1 !== 8'h01) begin n_fail++; $display("FAIL ctrl_readback: got %h, expected 01", d1); end
    bus_write(BASE + 8'd0, 8'd159);
    bus_write(BASE + 8'd1, 8'd119);
    exp_q.push_back({7'd119, 8'd159, 1'b1});
    bus_write(BASE + 8'd2, 8'h01);
    bus_read(BASE + 8'd0, d1, d2);
    n_checks++; if (d1 !== 8'd0) begin n_fail++; $display("FAIL autoinc_full_wrap_x: got %h, expected 00", d1); end
    bus_read(BASE + 8'd1, d1, d2);
    n_checks++; if (d1 !== 8'd0) begin n_fail++; $display("FAIL autoinc_full_wrap_y: got %h, expected 00", d1); end
    bus_write(BASE + 8'd0, 8'd159);
    bus_write(BASE + 8'd1, 8'd5);
    exp_q.push_back({7'd5, 8'd159, 1'b0});
    bus_write(BASE + 8'd2, 8'h00);
    bus_read(BASE + 8'd0, d1, d2);
    n_checks++; if (d1 !== 8'd0) begin n_fail++; $display("FAIL autoinc_line_wrap_x: got %h, expected 00", d1); end
    bus_read(BASE + 8'd1, d1, d2);
    n_checks++; if (d1 !== 8'd6) begin n_fail++; $display("FAIL autoinc_line_wrap_y: got %h, expected 06", d1); end
  endtask
  task automatic test_back_to_back();
    bus_write(BASE + 8'd0, 8'd10);
    bus_write(BASE + 8'd1, 8'd2);
    exp_q.push_back({7'd2, 8'd10, 1'b1});
    exp_q.push_back({7'd2, 8'd11, 1'b0});
    exp_q.push_back({7'd2, 8'd12, 1'b1});
    bus_write(BASE + 8'd2, 8'h01);
    bus_write(BASE + 8'd2, 8'h00);
    bus_write(BASE + 8'd2, 8'h01);
    bus_read(BASE + 8'd0, d1, d2);
    n_checks++; if (d1 !== 8'd13) begin n_fail++; $display("FAIL b2b_x: got %h, expected 0d", d1); end
    bus_write(BASE + 8'd3, 8'h00);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d, expected 0", exp_q.size()); end
  endtask
  task automatic test_colours();
    bus_write(BASE + 8'd5, 8'h34);
    @(negedge clk);
    n_checks++; if (colours !== 16'h0034) begin n_fail++; $display("FAIL colours_lo: got %h, expected 0034", colours); end
    bus_write(BASE + 8'd6, 8'h12);
    @(negedge clk);
    n_checks++; if (colours !== 16'h1234) begin n_fail++; $display("FAIL colours_hi: got %h, expected 1234", colours); end
    bus_read(BASE + 8'd6, d1, d2);
    n_checks++; if (d1 !== 8'h12) begin n_fail++; $display("FAIL colours_readback: got %h, expected 12", d1); end
  endtask
  task automatic test_bus_read();
    bus_write(BASE + 8'd0, 8'h2A);
    bus_read(BASE + 8'd0, d1, d2);
    n_checks++; if (d1 !== 8'h2A) begin n_fail++; $display("FAIL read_x: got %h, expected 2a", d1); end
    n_checks++; if (d2 !== 8'hFF) begin n_fail++; $display("FAIL read_release: got %h, expected ff (pulled up)", d2); end
    bus_read(8'hB8, d1, d2);
    n_checks++; if (d1 !== 8'hFF || d2 !== 8'hFF) begin n_fail++; $display("FAIL read_above_range: got %h %h, expected ff ff", d1, d2); end
    bus_read(8'hAF, d1, d2);
    n_checks++; if (d1 !== 8'hFF || d2 !== 8'hFF) begin n_fail++; $display("FAIL read_below_range: got %h %h, expected ff ff", d1, d2); end
    bus_write(BASE + 8'd4, 8'hFF);
    bus_read(BASE + 8'd4, d1, d2);
    n_checks++; if (d1 !== 8'h00) begin n_fail++; $display("FAIL status_write_ignored: got %h, expected 00", d1); end
    bus_write(BASE + 8'd7, 8'h81);
    bus_read(BASE + 8'd7, d1, d2);
    n_checks++; if (d1 !== 8'h81) begin n_fail++; $display("FAIL fill_val_readback: got %h, expected 81", d1); end
  endtask
  task automatic test_fill();
    int w0, cyc;
    bus_write(BASE + 8'd7, 8'h01);
    for (int i = 0; i < 19200; i++) exp_q.push_back({7'(i / 160), 8'(i % 160), 1'b1});
    w0 = we_cnt;
    bus_write(BASE + 8'd3, 8'h02);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %b, expected 1", busy); end
    bus_read(BASE + 8'd4, d1, d2);
    n_checks++; if (d1 !== 8'h01) begin n_fail++; $display("FAIL fill_status_busy: got %h, expected 01", d1); end
    bus_write(BASE + 8'd0, 8'd99);
    bus_write(BASE + 8'd2, 8'h00);
    bus_write(BASE + 8'd3, 8'h02);
    bus_write(BASE + 8'd7, 8'h00);
    cyc = 0;
    while (irq !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL fill_done_irq: got %b, expected 1 within 20000 cycles", irq); end
    n_checks++; if (we_cnt - w0 != 19200) begin n_fail++; $display("FAIL fill_write_count: got %0d, expected 19200", we_cnt - w0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fill_pending: got %0d, expected 0", exp_q.size()); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b0 || busy !== 1'b0 || fb_we !== 1'b0) begin n_fail++; $display("FAIL fill_after: got irq=%b busy=%b we=%b, expected 0 0 0", irq, busy, fb_we); end
    bus_read(BASE + 8'd4, d1, d2);
    n_checks++; if (d1 !== 8'h02) begin n_fail++; $display("FAIL fill_status_done: got %h, expected 02", d1); end
    bus_read(BASE + 8'd4, d1, d2);
    n_checks++; if (d1 !== 8'h00) begin n_fail++; $display("FAIL fill_status_cleared: got %h, expected 00", d1); end
    bus_read(BASE + 8'd0, d1, d2);
    n_checks++; if (d1 !== 8'h2A) begin n_fail++; $display("FAIL fill_x_untouched: got %h, expected 2a", d1); end
    bus_read(BASE + 8'd7, d1, d2);
    n_checks++; if (d1 !== 8'h01) begin n_fail++; $display("FAIL fill_val_locked: got %h, expected 01", d1); end
    bus_write(BASE + 8'd0, 8'd5);
    bus_write(BASE + 8'd1, 8'd3);
    bus_read(BASE + 8'd2, d1, d2);
    n_checks++; if (d1 !== 8'h01) begin n_fail++; $display("FAIL fill_pixel: got %h, expected 01", d1); end
  endtask
  task automatic test_abort();
    bus_write(BASE + 8'd7, 8'h00);
    for (int i = 0; i < 12; i++) exp_q.push_back({7'd0, 8'(i), 1'b0});
    bus_write(BASE + 8'd3, 8'h02);
    repeat (10) step();
    bus_write(BASE + 8'd3, 8'h04);
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_stop: got we=%b busy=%b, expected 0 0", fb_we, busy); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL abort_irq: got %b, expected 1", irq); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_pending: got %0d, expected 0", exp_q.size()); end
    bus_read(BASE + 8'd4, d1, d2);
    n_checks++; if (d1 !== 8'h02) begin n_fail++; $display("FAIL abort_status: got %h, expected 02", d1); end
    bus_write(BASE + 8'd0, 8'd0);
    bus_write(BASE + 8'd1, 8'd0);
    bus_read(BASE + 8'd2, d1, d2);
    n_checks++; if (d1 !== 8'h00) begin n_fail++; $display("FAIL abort_pixel: got %h, expected 00", d1); end
  endtask
  task automatic test_reset_mid_fill();
    bus_write(BASE + 8'd7, 8'h01);
    for (int i = 0; i < 12; i++) exp_q.push_back({7'd0, 8'(i), 1'b1});
    bus_write(BASE + 8'd3, 8'h02);
    repeat (10) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (fb_we !== 1'b0 || busy !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL rst_fill_stop: got we=%b busy=%b irq=%b, expected 0 0 0", fb_we, busy, irq); end
    n_checks++; if (colours !== 16'h0000) begin n_fail++; $display("FAIL rst_fill_colours: got %h, expected 0000", colours); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_fill_pending: got %0d, expected 0", exp_q.size()); end
    bus_read(BASE + 8'd4, d1, d2);
    n_checks++; if (d1 !== 8'h00) begin n_fail++; $display("FAIL rst_fill_status: got %h, expected 00", d1); end
    bus_read(BASE + 8'd7, d1, d2);
    n_checks++; if (d1 !== 8'h00) begin n_fail++; $display("FAIL rst_fill_val: got %h, expected 00", d1); end
  endtask
  initial begin
    test_reset();
    test_pixel_write();
    test_auto_inc();
    test_back_to_back();
    test_colours();
    test_bus_read();
    test_fill();
    test_abort();
    test_reset_mid_fill();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
